// File: rtl/sme_driver.sv
// Host-side loader for the string-matching engine: buffers string/pattern characters,
// streams them to SME on start, then holds the SME result under a valid/ready handshake.
module sme_driver #(
  parameter int unsigned STR_MAX = 32,
  parameter int unsigned PAT_MAX = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic       keep_str,
  output logic       busy,
  output logic       overflow,
  output logic       start_err,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_match,
  input  logic [4:0] sme_index,
  input  logic       sme_valid,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout,
  input  logic       res_ready
);

  localparam int unsigned SIW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
  localparam int unsigned PIW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
  localparam int unsigned SLW = $clog2(STR_MAX + 1);
  localparam int unsigned PLW = $clog2(PAT_MAX + 1);
  localparam int unsigned CW  = (SIW > PIW) ? SIW : PIW;
  localparam int unsigned WW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {StIdle, StSendStr, StSendPat, StWait, StHold} state_e;

  state_e         state_q;
  logic [SLW-1:0] str_len_q;
  logic [PLW-1:0] pat_len_q;
  logic [CW-1:0]  cnt_q;
  logic [WW-1:0]  wcnt_q;
  logic [7:0]     str_buf [STR_MAX];
  logic [7:0]     pat_buf [PAT_MAX];

  logic          str_full;
  logic          pat_full;
  logic          start_ok;
  logic          str_we;
  logic          pat_we;
  logic          str_last;
  logic          pat_last;
  logic [CW-1:0] cnt_nxt;

  assign str_full = (str_len_q == SLW'(STR_MAX));
  assign pat_full = (pat_len_q == PLW'(PAT_MAX));
  assign start_ok = (pat_len_q != '0) && (keep_str || (str_len_q != '0));
  // start has priority over a simultaneous write
  assign str_we   = (state_q == StIdle) && wr_en && !start && !wr_sel && !str_full;
  assign pat_we   = (state_q == StIdle) && wr_en && !start && wr_sel && !pat_full;
  assign cnt_nxt  = cnt_q + CW'(1);
  // cnt_q indexes the character currently on chardata
  assign str_last = ((SLW'(cnt_q) + SLW'(1)) == str_len_q);
  assign pat_last = ((PLW'(cnt_q) + PLW'(1)) == pat_len_q);
  assign busy     = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (str_we) str_buf[SIW'(str_len_q)] <= wr_data;
    if (pat_we) pat_buf[PIW'(pat_len_q)] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      str_len_q   <= '0;
      pat_len_q   <= '0;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      overflow    <= 1'b0;
      start_err   <= 1'b0;
      chardata    <= 8'd0;
      isstring    <= 1'b0;
      ispattern   <= 1'b0;
      res_valid   <= 1'b0;
      res_match   <= 1'b0;
      res_index   <= 5'd0;
      res_timeout <= 1'b0;
    end else begin
      start_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (start_ok) begin
              overflow <= 1'b0;
              cnt_q    <= '0;
              if (keep_str) begin
                state_q   <= StSendPat;
                ispattern <= 1'b1;
                chardata  <= pat_buf[0];
              end else begin
                state_q  <= StSendStr;
                isstring <= 1'b1;
                chardata <= str_buf[0];
              end
            end else begin
              start_err <= 1'b1;
            end
          end else if (wr_en) begin
            if (!wr_sel) begin
              if (str_full) overflow <= 1'b1;
              else          str_len_q <= str_len_q + SLW'(1);
            end else begin
              if (pat_full) overflow <= 1'b1;
              else          pat_len_q <= pat_len_q + PLW'(1);
            end
          end
        end

        StSendStr: begin
          if (str_last) begin
            state_q   <= StSendPat;
            isstring  <= 1'b0;
            ispattern <= 1'b1;
            chardata  <= pat_buf[0];
            cnt_q     <= '0;
          end else begin
            cnt_q    <= cnt_nxt;
            chardata <= str_buf[SIW'(cnt_nxt)];
          end
        end

        StSendPat: begin
          if (pat_last) begin
            state_q   <= StWait;
            ispattern <= 1'b0;
            chardata  <= 8'd0;
            wcnt_q    <= '0;
          end else begin
            cnt_q    <= cnt_nxt;
            chardata <= pat_buf[PIW'(cnt_nxt)];
          end
        end

        StWait: begin
          if (sme_valid) begin
            state_q     <= StHold;
            res_valid   <= 1'b1;
            res_match   <= sme_match;
            res_index   <= sme_index;
            res_timeout <= 1'b0;
            str_len_q   <= '0;
            pat_len_q   <= '0;
          end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
            state_q     <= StHold;
            res_valid   <= 1'b1;
            res_match   <= 1'b0;
            res_index   <= 5'd0;
            res_timeout <= 1'b1;
            str_len_q   <= '0;
            pat_len_q   <= '0;
          end else begin
            wcnt_q <= wcnt_q + WW'(1);
          end
        end

        StHold: begin
          if (res_ready) begin
            state_q   <= StIdle;
            res_valid <= 1'b0;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sme_driver.sv
// Randomized bench for sme_driver: a queue-based model of the host buffers predicts the load
// stream and result handshake; a simple SME model supplies results after random delays.
module tb_sme_driver;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, wr_sel, start, keep_str;
  logic [7:0] wr_data;
  logic       busy, overflow, start_err;
  logic [7:0] chardata;
  logic       isstring, ispattern;
  logic       sme_match, sme_valid;
  logic [4:0] sme_index;
  logic       res_valid, res_match, res_timeout, res_ready;
  logic [4:0] res_index;

  sme_driver #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .start      (start),
    .keep_str   (keep_str),
    .busy       (busy),
    .overflow   (overflow),
    .start_err  (start_err),
    .chardata   (chardata),
    .isstring   (isstring),
    .ispattern  (ispattern),
    .sme_match  (sme_match),
    .sme_index  (sme_index),
    .sme_valid  (sme_valid),
    .res_valid  (res_valid),
    .res_match  (res_match),
    .res_index  (res_index),
    .res_timeout(res_timeout),
    .res_ready  (res_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // host-visible buffer contents and sticky overflow, as the host believes them to be
  logic [7:0] str_q[$];
  logic [7:0] pat_q[$];
  bit         ovf_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_data = d;
    tick();
    wr_en = 1'b0;
    if (!sel) begin
      if (str_q.size() < STR_MAX) str_q.push_back(d);
      else                        ovf_m = 1'b1;
    end else begin
      if (pat_q.size() < PAT_MAX) pat_q.push_back(d);
      else                        ovf_m = 1'b1;
    end
  endtask

  task automatic wr_str(input string s, input bit sel);
    for (int i = 0; i < s.len(); i++) wr(sel, s[i]);
  endtask

  // dly < 0: SME never answers
  task automatic run_job(input bit keep, input int dly, input bit m, input logic [4:0] idx,
                         input int hold);
    logic [9:0] exp_seq[$];
    bit         ok;
    int         n;
    logic       exp_m, exp_to;
    logic [4:0] exp_i;
    ok = (pat_q.size() != 0) && (keep || str_q.size() != 0);
    start = 1'b1; keep_str = keep;
    wr_en = 1'($urandom_range(0, 1)); wr_sel = 1'($urandom_range(0, 1));
    wr_data = 8'($urandom);
    tick();
    start = 1'b0; wr_en = 1'b0;
    if (ok) ovf_m = 1'b0;
    check("start_err", start_err, !ok);
    check("busy_after_start", busy, ok);
    check("overflow_after_start", overflow, ovf_m);
    if (!ok) begin
      tick();
      check("start_err_pulse", start_err, 1'b0);
      check("busy_after_reject", busy, 1'b0);
      return;
    end
    if (!keep) foreach (str_q[i]) exp_seq.push_back({2'b10, str_q[i]});
    foreach (pat_q[i]) exp_seq.push_back({2'b01, pat_q[i]});
    foreach (exp_seq[i]) begin
      check("load", {isstring, ispattern, chardata}, exp_seq[i]);
      tick();
    end
    check("end_marker", {busy, isstring, ispattern, chardata, res_valid}, {1'b1, 11'd0});
    if (dly < 0) begin
      n = 1;
      while (res_valid !== 1'b1 && n < 400) begin
        wr_en = 1'($urandom_range(0, 1)); wr_data = 8'($urandom);
        sme_match = 1'($urandom); sme_index = 5'($urandom);
        tick();
        if (res_valid !== 1'b1) n++;
      end
      wr_en = 1'b0;
      check("wait_cycles", n, TIMEOUT);
      exp_m = 1'b0; exp_i = 5'd0; exp_to = 1'b1;
    end else begin
      repeat (dly) begin
        wr_en = 1'($urandom_range(0, 1)); wr_sel = 1'($urandom); wr_data = 8'($urandom);
        sme_match = 1'($urandom); sme_index = 5'($urandom);
        tick();
      end
      wr_en = 1'b0;
      sme_valid = 1'b1; sme_match = m; sme_index = idx;
      tick();
      sme_valid = 1'b0;
      exp_m = m; exp_i = idx; exp_to = 1'b0;
    end
    str_q.delete();
    pat_q.delete();
    check("result", {res_valid, res_match, res_index, res_timeout}, {1'b1, exp_m, exp_i, exp_to});
    for (int i = 0; i < hold; i++) begin
      sme_valid = 1'($urandom); sme_match = 1'($urandom); sme_index = 5'($urandom);
      res_ready = 1'b0;
      tick();
      check("hold_stable", {busy, res_valid, res_match, res_index, res_timeout},
            {2'b11, exp_m, exp_i, exp_to});
    end
    sme_valid = 1'b0; res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("release", {busy, res_valid, res_match, res_index, res_timeout},
          {2'b00, exp_m, exp_i, exp_to});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int nw, dly;
    reset = 1'b0;
    wr_en = 0; wr_sel = 0; wr_data = 0; start = 0; keep_str = 0;
    sme_match = 0; sme_index = 0; sme_valid = 0; res_ready = 0;
    ovf_m = 1'b0;
    tick(); tick();
    check("reset_outputs",
          {busy, overflow, start_err, chardata, isstring, ispattern, res_valid, res_match,
           res_index, res_timeout}, 0);
    reset = 1'b1;
    tick();

    wr_str("ab cd", 1'b0);
    wr_str("cd", 1'b1);
    check("overflow_clean", overflow, 1'b0);
    run_job(1'b0, 3, 1'b1, 5'd3, 2);

    wr_str("^a", 1'b1);
    run_job(1'b1, 5, 1'b1, 5'd7, 1);

    run_job(1'b0, 0, 1'b0, 5'd0, 0);
    wr_str("q", 1'b1);
    run_job(1'b0, 0, 1'b0, 5'd0, 0);

    for (int i = 0; i < 33; i++) wr(1'b0, 8'($urandom_range(32, 126)));
    check("overflow_set", overflow, 1'b1);
    run_job(1'b0, 10, 1'b1, 5'd17, 10);

    wr_str("zz", 1'b1);
    run_job(1'b1, -1, 1'b0, 5'd0, 10);

    wr_str("k", 1'b1);
    run_job(1'b1, TIMEOUT - 1, 1'b1, 5'd9, 0);

    wr_str("xyz", 1'b0);
    wr_str("pq", 1'b1);
    start = 1'b1; keep_str = 1'b0;
    tick();
    start = 1'b0;
    check("mid_busy", busy, 1'b1);
    tick(); tick(); tick();
    check("mid_pat", {isstring, ispattern, chardata}, {2'b01, 8'h70});
    #2 reset = 1'b0;
    #1 check("async_reset", {busy, isstring, ispattern, chardata, res_valid}, 0);
    str_q.delete(); pat_q.delete(); ovf_m = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    run_job(1'b1, 0, 1'b0, 5'd0, 0);
    wr_str("z", 1'b1);
    run_job(1'b0, 0, 1'b0, 5'd0, 0);

    for (int j = 0; j < 24; j++) begin
      nw = $urandom_range(0, 44);
      for (int i = 0; i < nw; i++)
        wr(1'($urandom_range(0, 3) == 0), 8'($urandom));
      check("overflow_model", overflow, ovf_m);
      dly = $urandom_range(0, 30);
      if ($urandom_range(0, 9) == 0) dly = -1;
      else if ($urandom_range(0, 9) == 0) dly = TIMEOUT - 1;
      run_job(1'($urandom), dly, 1'($urandom), 5'($urandom), $urandom_range(0, 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
